// File: rtl/i2c_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_mon_pkg
//  Description : Constants and types shared by the I2C monitor blocks:
//                ASCII codes, the in-band overflow marker word and the
//                transmit scheduler state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_mon_pkg;

    localparam logic [7:0] ASCII_STX   = 8'h02;
    localparam logic [7:0] ASCII_ETX   = 8'h03;
    localparam logic [7:0] ASCII_ACK   = 8'h06;
    localparam logic [7:0] ASCII_NAK   = 8'h15;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BANG  = 8'h21;

    // Word sent to the host once per overflow episode ("!!")
    localparam logic [15:0] MARKER_WORD = {ASCII_BANG, ASCII_BANG};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_HOLD_HI = 3'd3,
        ST_WAIT_HI = 3'd4,
        ST_SEND_LO = 3'd5,
        ST_HOLD_LO = 3'd6,
        ST_WAIT_LO = 3'd7
    } sched_state_t;

endpackage : i2c_mon_pkg
`default_nettype wire

// File: rtl/sync_fifo_16.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_16
//  Description : Single-clock FIFO of 16-bit words. Occupancy is tracked in
//                a separate level counter so pointers can wrap freely and
//                full/empty are unambiguous.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_16 #(
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [15:0]              i_wdata,
    input  logic                     i_pop,
    output logic [15:0]              o_rdata,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int                 c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]      c_full_lvl = (c_aw + 1)'(DEPTH);

    logic [15:0]     r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw:0]   r_level;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_full    = (r_level == c_full_lvl);
    assign o_empty   = (r_level == '0);
    // A push into a full FIFO is legal only when a pop frees a slot this cycle
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage array; contents need no reset since the level gates reads
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : sync_fifo_16
`default_nettype wire

// File: rtl/i2c_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_tx_scheduler
//  Description : Queues two-character words from the I2C parser and feeds
//                them, high byte first, into a byte-wide UART transmitter.
//                Dropped words are counted and announced with a "!!" marker.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_tx_scheduler
    import i2c_mon_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [15:0]              i_word,
    input  logic                     i_word_en,
    input  logic                     i_tx_busy,
    output logic [7:0]               o_tx_data,
    output logic                     o_tx_start,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_overflow,
    output logic [DROP_W-1:0]        o_drop_count
);

    sched_state_t r_state;
    sched_state_t w_next;

    logic [15:0]       w_rdata;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_drop;
    logic              w_tx_start;
    logic [15:0]       w_load_word;

    logic              r_src_mark;
    logic              r_mark_pend;
    logic [7:0]        r_cur_lo;
    logic [7:0]        r_tx_data;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;

    // Only a FIFO-sourced LOAD consumes an entry
    assign w_pop       = (r_state == ST_LOAD) && !r_src_mark;
    assign w_push_ok   = i_word_en && (!w_full || w_pop);
    assign w_drop      = i_word_en && !w_push_ok;
    assign w_load_word = r_src_mark ? MARKER_WORD : w_rdata;

    sync_fifo_16 #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push_ok),
        .i_wdata (i_word),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_level (o_level),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and start-pulse decode
    always_comb begin
        w_next     = r_state;
        w_tx_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_mark_pend || !w_empty) begin
                    w_next = ST_LOAD;
                end
            end
            ST_LOAD:    w_next = ST_SEND_HI;
            ST_SEND_HI: begin
                w_tx_start = 1'b1;
                w_next     = ST_HOLD_HI;
            end
            // Busy may not have risen yet, so it is not looked at here
            ST_HOLD_HI: w_next = ST_WAIT_HI;
            ST_WAIT_HI: begin
                if (!i_tx_busy) begin
                    w_next = ST_SEND_LO;
                end
            end
            ST_SEND_LO: begin
                w_tx_start = 1'b1;
                w_next     = ST_HOLD_LO;
            end
            ST_HOLD_LO: w_next = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!i_tx_busy) begin
                    w_next = ST_IDLE;
                end
            end
            default:    w_next = ST_IDLE;
        endcase
    end

    // Word latch and output byte register; the byte is loaded on entry to a SEND state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_src_mark <= 1'b0;
            r_cur_lo   <= '0;
            r_tx_data  <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_src_mark <= r_mark_pend;
            end
            if (r_state == ST_LOAD) begin
                r_cur_lo  <= w_load_word[7:0];
                r_tx_data <= w_load_word[15:8];
            end
            if ((r_state == ST_WAIT_HI) && !i_tx_busy) begin
                r_tx_data <= r_cur_lo;
            end
        end
    end

    // Overflow tracking; a drop re-arms the marker even during a marker load
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mark_pend  <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            if (w_drop) begin
                r_mark_pend <= 1'b1;
                r_overflow  <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end else if ((r_state == ST_LOAD) && r_src_mark) begin
                r_mark_pend <= 1'b0;
            end
        end
    end

    assign o_tx_data    = r_tx_data;
    assign o_tx_start   = w_tx_start;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_drop_count;

endmodule : i2c_tx_scheduler
`default_nettype wire

// File: tb/tb_i2c_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_tx_scheduler
//  Description : Self-checking bench for i2c_tx_scheduler (DEPTH=4, DROP_W=2)
//                with a simple UART busy model and byte log.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_tx_scheduler;

    localparam int DEPTH    = 4;
    localparam int DROP_W   = 2;
    localparam int BUSY_CYC = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic [15:0]       word;
    logic              word_en;
    logic              tx_busy;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic [2:0]        level;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    logic hold_busy;
    logic uart_busy;
    logic auto_en;

    int          n_checks;
    int          n_pass;
    int          cyc;
    int          peak;
    int          ub_cnt;
    bit          pend;
    bit          prev_start;
    bit          stab_ok;
    logic [7:0]  cur_d;
    logic [7:0]  log_q[$];
    int          log_cyc[$];
    logic [7:0]  exp_q[$];

    typedef struct {
        logic [15:0] w;
        logic [7:0]  hi;
        logic [7:0]  lo;
    } vec_t;
    vec_t vecs[4];

    assign tx_busy = hold_busy | uart_busy;

    always #5 clk = ~clk;

    i2c_tx_scheduler #(
        .DEPTH  (DEPTH),
        .DROP_W (DROP_W)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_word       (word),
        .i_word_en    (word_en),
        .i_tx_busy    (tx_busy),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_level      (level),
        .o_overflow   (overflow),
        .o_drop_count (drop_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock step; also runs the UART model and logs start pulses
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            uart_busy  = 1'b0;
            ub_cnt     = 0;
            pend       = 1'b0;
            prev_start = 1'b0;
            return;
        end
        if (32'(level) > peak) peak = 32'(level);
        if (prev_start) check("start_width", 32'(tx_start), 32'd0);
        if (pend) begin
            pend      = 1'b0;
            uart_busy = 1'b1;
            ub_cnt    = BUSY_CYC;
            stab_ok   = 1'b1;
        end else if (uart_busy) begin
            if (tx_data !== cur_d) stab_ok = 1'b0;
            ub_cnt--;
            if (ub_cnt == 0) begin
                uart_busy = 1'b0;
                check("data_stable", 32'(stab_ok), 32'd1);
            end
        end
        if (tx_start) begin
            check("start_while_busy", 32'(tx_busy), 32'd0);
            log_q.push_back(tx_data);
            log_cyc.push_back(cyc);
            cur_d = tx_data;
            if (auto_en) pend = 1'b1;
        end
        prev_start = tx_start;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [15:0] w);
        word    = w;
        word_en = 1'b1;
        tick();
        word_en = 1'b0;
    endtask

    task automatic wait_bytes(input int n, input int limit);
        for (int t = 0; t < limit && log_q.size() < n; t++) tick();
        check("byte_timeout", 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic compare_seq(input string name, input int base);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < log_q.size())
                check(name, 32'(log_q[base+i]), 32'(exp_q[i]));
            else
                check(name, 32'hDEAD, 32'(exp_q[i]));
        end
    endtask

    initial begin
        int base;
        int k;
        n_checks  = 0;
        n_pass    = 0;
        cyc       = 0;
        peak      = 0;
        ub_cnt    = 0;
        pend      = 1'b0;
        prev_start = 1'b0;
        stab_ok   = 1'b1;
        cur_d     = '0;
        rst       = 1'b1;
        word      = '0;
        word_en   = 1'b0;
        hold_busy = 1'b0;
        uart_busy = 1'b0;
        auto_en   = 1'b1;

        vecs[0] = '{w: 16'h0220, hi: 8'h02, lo: 8'h20};
        vecs[1] = '{w: 16'h0306, hi: 8'h03, lo: 8'h06};
        vecs[2] = '{w: 16'h150A, hi: 8'h15, lo: 8'h0A};
        vecs[3] = '{w: 16'hA55A, hi: 8'hA5, lo: 8'h5A};

        // Reset values
        ticks(3);
        check("rst_start",    32'(tx_start),   32'd0);
        check("rst_data",     32'(tx_data),    32'd0);
        check("rst_level",    32'(level),      32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        check("rst_drop",     32'(drop_count), 32'd0);
        rst = 1'b0;
        ticks(2);

        // Single words: byte order, push-to-start latency, level update
        for (int v = 0; v < 4; v++) begin
            base = log_q.size();
            k    = cyc;
            push(vecs[v].w);
            check("level_after_push", 32'(level), 32'd1);
            wait_bytes(base + 2, 80);
            check("single_hi", 32'(log_q[base]),   32'(vecs[v].hi));
            check("single_lo", 32'(log_q[base+1]), 32'(vecs[v].lo));
            check("latency",   32'(log_cyc[base] - k), 32'd3);
            ticks(20);
            check("single_level_end", 32'(level), 32'd0);
        end

        // Burst of five back-to-back words
        base = log_q.size();
        peak = 0;
        push(16'h4142); push(16'h4344); push(16'h4546); push(16'h4748); push(16'h494A);
        wait_bytes(base + 10, 400);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48, 8'h49, 8'h4A};
        compare_seq("burst_byte", base);
        ticks(20);
        check("burst_peak",  32'(peak),       32'd4);
        check("burst_level", 32'(level),      32'd0);
        check("burst_drop",  32'(drop_count), 32'd0);

        // Overflow: one word in flight, four queued, three dropped
        do_reset();
        base = log_q.size();
        push(16'h3031);
        wait_bytes(base + 1, 20);
        tick();
        hold_busy = 1'b1;
        push(16'h3233); push(16'h3435); push(16'h3637); push(16'h3839);
        push(16'h4A4B); push(16'h4C4D); push(16'h4E4F);
        check("ovf_drop",     32'(drop_count), 32'd3);
        check("ovf_overflow", 32'(overflow),   32'd1);
        check("ovf_level",    32'(level),      32'd4);
        hold_busy = 1'b0;
        wait_bytes(base + 12, 700);
        exp_q = '{8'h30, 8'h31, 8'h21, 8'h21, 8'h32, 8'h33, 8'h34, 8'h35,
                  8'h36, 8'h37, 8'h38, 8'h39};
        compare_seq("ovf_byte", base);
        ticks(60);
        check("ovf_no_extra", 32'(log_q.size()), 32'(base + 12));

        // Push while LOAD pops from a full FIFO
        do_reset();
        auto_en = 1'b0;
        base = log_q.size();
        push(16'h6162);
        wait_bytes(base + 1, 20);
        tick();
        hold_busy = 1'b1;
        push(16'h6364); push(16'h6566); push(16'h6768); push(16'h696A);
        ticks(2);
        check("fp_full_level", 32'(level), 32'd4);
        hold_busy = 1'b0;          // WAIT_HI releases
        tick();                    // SEND_LO
        check("fp_lo_start", 32'(tx_start), 32'd1);
        tick();                    // HOLD_LO
        hold_busy = 1'b1;
        ticks(2);                  // WAIT_LO, busy held
        hold_busy = 1'b0;          // WAIT_LO releases
        ticks(2);                  // IDLE, then LOAD
        auto_en = 1'b1;
        push(16'h6B6C);            // push during LOAD
        check("fp_level", 32'(level),      32'd4);
        check("fp_drop",  32'(drop_count), 32'd0);
        check("fp_ovf",   32'(overflow),   32'd0);
        wait_bytes(base + 12, 700);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68,
                  8'h69, 8'h6A, 8'h6B, 8'h6C};
        compare_seq("fp_byte", base);

        // Drop counter saturation, then reset while in WAIT_LO
        do_reset();
        auto_en = 1'b0;
        base = log_q.size();
        push(16'h7A7B);
        wait_bytes(base + 1, 20);
        tick();
        hold_busy = 1'b1;
        push(16'h0101); push(16'h0202); push(16'h0303); push(16'h0404);
        push(16'h0505); push(16'h0606);
        check("sat_drop2", 32'(drop_count), 32'd2);
        push(16'h0707); push(16'h0808); push(16'h0909); push(16'h0A0A);
        check("sat_drop_hold", 32'(drop_count), 32'd3);
        check("sat_overflow",  32'(overflow),   32'd1);
        hold_busy = 1'b0;
        tick();                    // SEND_LO
        check("mid_lo_data", 32'(tx_data), 32'h7B);
        tick();                    // HOLD_LO
        hold_busy = 1'b1;
        tick();                    // WAIT_LO
        #2;
        rst = 1'b1;
        #1;
        check("midrst_start", 32'(tx_start),   32'd0);
        check("midrst_data",  32'(tx_data),    32'd0);
        check("midrst_level", 32'(level),      32'd0);
        check("midrst_ovf",   32'(overflow),   32'd0);
        check("midrst_drop",  32'(drop_count), 32'd0);
        tick();
        rst       = 1'b0;
        hold_busy = 1'b0;
        auto_en   = 1'b1;
        base = log_q.size();
        ticks(40);
        check("midrst_quiet", 32'(log_q.size()), 32'(base));
        k = cyc;
        push(16'h0D0A);
        wait_bytes(base + 2, 80);
        check("post_rst_hi",  32'(log_q[base]),   32'h0D);
        check("post_rst_lo",  32'(log_q[base+1]), 32'h0A);
        check("post_rst_lat", 32'(log_cyc[base] - k), 32'd3);
        ticks(20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_i2c_tx_scheduler
`default_nettype wire
